// File: rtl/debounce_pkg.sv
// Shared types and widths for the signal debouncer.
// The optional glitch counter is enabled by defining DEBOUNCE_GLITCH_CNT_EN.
package debounce_pkg;

    localparam int unsigned GLITCH_CNT_W = 8;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } debounce_state_e;

    // Counter width able to hold values up to stable_cycles
    function automatic int unsigned cnt_width(input int unsigned stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer bringing an asynchronous bit into the clk domain.
module bit_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
        end
    end

    assign q = sync[STAGES-1];

endmodule

// File: rtl/signal_debouncer.sv
// Synchronizes raw_in and accepts a new level only after STABLE_CYCLES equal samples.
// Define DEBOUNCE_GLITCH_CNT_EN to add the saturating glitch_cnt output.
module signal_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    raw_in,
    output logic                    sig_out,
    output logic                    busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

    localparam int unsigned          CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

    debounce_state_e  state;
    logic [CNT_W-1:0] cnt;
    logic             sync_in;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_in),
        .q   (sync_in)
    );

    // Qualification FSM; sample-before-accept means a reversal on the final count rejects
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= STABLE_LO;
            cnt     <= '0;
            sig_out <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                STABLE_LO: begin
                    if (sync_in) begin
                        state <= CHK_HI;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                CHK_HI: begin
                    if (!sync_in) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= STABLE_HI;
                        cnt     <= '0;
                        sig_out <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!sync_in) begin
                        state <= CHK_LO;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                CHK_LO: begin
                    if (sync_in) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= STABLE_LO;
                        cnt     <= '0;
                        sig_out <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic reject_c;

    assign reject_c = ((state == CHK_HI) && !sync_in) ||
                      ((state == CHK_LO) &&  sync_in);

    // Saturating count of candidate changes abandoned before acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_cnt <= '0;
        end else if (reject_c && (glitch_cnt != '1)) begin
            glitch_cnt <= glitch_cnt + GLITCH_CNT_W'(1);
        end
    end
`endif

endmodule

// File: doc/signal_debouncer.md
SIGNAL_DEBOUNCER -- requirements
Module: signal_debouncer

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16: consecutive equal synchronized samples needed to accept a new level; legal range 2..65535.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop depth; legal range 2..4.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port raw_in  input  1  asynchronous, possibly bouncing signal (switch, pin).
REQ-006 SHALL have port sig_out  output  1  debounced, clk-synchronous level; drives the downstream edge detector's sig_in.
REQ-007 SHALL have port busy  output  1  high while a candidate level change is being qualified.
REQ-008 SHALL have port glitch_cnt  output  8  rejected-transition count; present only under DEBOUNCE_GLITCH_CNT_EN.

Function
REQ-009 SHALL pass raw_in through a SYNC_STAGES-deep flop chain; the last stage is sync_in; nothing else samples raw_in.
REQ-010 SHALL implement FSM states STABLE_LO, CHK_HI, STABLE_HI, CHK_LO.
REQ-011 SHALL use a counter cnt of width $clog2(STABLE_CYCLES+1), zero on every entry to a STABLE_* state.
REQ-012 STABLE_LO: sync_in=1 -> CHK_HI, cnt<=1; else stay.
REQ-013 CHK_HI: sync_in=0 -> STABLE_LO, cnt<=0 (rejected); sync_in=1 and cnt==STABLE_CYCLES-1 -> STABLE_HI, sig_out<=1; otherwise cnt<=cnt+1.
REQ-014 STABLE_HI / CHK_LO SHALL mirror REQ-012/013 with polarities inverted; acceptance drives sig_out<=0.
REQ-015 sig_out SHALL be a register, change only on acceptance, never glitch, and change at most once per acceptance.
REQ-016 Latency: clean raw_in step held steady -> sig_out changes exactly SYNC_STAGES+STABLE_CYCLES rising edges after the first edge sampling the new level.
REQ-017 busy SHALL be registered, high exactly in CHK_HI/CHK_LO.
REQ-018 cnt SHALL never exceed STABLE_CYCLES-1; no wrap-around is possible.
REQ-019 A reversal on the same cycle cnt would reach its limit SHALL count as rejection (sample-before-accept).

Reset
REQ-020 rst high SHALL immediately force: sync chain all 0, state STABLE_LO, cnt 0, sig_out 0, busy 0, glitch_cnt 0.
REQ-021 Reset mid-qualification SHALL discard progress; after release a full STABLE_CYCLES qualification is required again.
REQ-022 raw_in activity during reset SHALL have no effect on any output.

Configuration
REQ-023 With DEBOUNCE_GLITCH_CNT_EN defined, glitch_cnt port and register SHALL exist, incrementing by 1 on each rejection (REQ-013/014), saturating at 255.
REQ-024 Without DEBOUNCE_GLITCH_CNT_EN, port and register SHALL be absent; all other behaviour identical.

Structure
REQ-025 Package debounce_pkg SHALL hold the FSM state enum (debounce_state_e) and GLITCH_CNT_W = 8.
REQ-026 Synchronizer SHALL be sub-module bit_synchronizer (parameter STAGES, ports clk, rst, d, q), instantiated once.
REQ-027 FSM, counter and optional glitch counter SHALL reside in signal_debouncer; no combinational path from raw_in to any output.

Verification (STABLE_CYCLES=4, SYNC_STAGES=2, macro defined unless noted)
REQ-028 Reset: rst=1, raw_in toggling 10 cycles -> sig_out=0, busy=0, glitch_cnt=0 throughout; release -> still 0.
REQ-029 Clean rise: raw_in 0->1 held -> busy high from edge 3, sig_out=1 exactly 6 edges after; downstream edge detector emits one pulse_out_p.
REQ-030 Bounce: raw_in 1 for 3 cycles then 0 -> sig_out stays 0, glitch_cnt=1; then 1 held 10 cycles -> sig_out=1, glitch_cnt=1.
REQ-031 Clean fall from sig_out=1: raw_in 1->0 held -> sig_out=0 exactly 6 edges later.
REQ-032 Mid-qualification reset: raw_in=1 held, rst pulse at edge 4 -> sig_out=0; after release sig_out=1 only 6 edges later.
REQ-033 Saturation: 300 rejected 2-cycle pulses -> glitch_cnt=255; without macro, same stimulus compiles and sig_out stays 0.
